// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings and decode helpers for the ARM multicycle sequencer.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_ORR = 3'b011;

  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100,
                         CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                         COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                         COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
                         COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf;

  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALU = 2'd2;
  localparam logic [1:0] SRCB_REG = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;
  localparam logic       SRCA_REG = 1'b0, SRCA_PC = 1'b1;
  localparam logic       ADR_PC = 1'b0, ADR_ALUOUT = 1'b1;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       valid;
    logic       is_cmp;
    logic       sets_cv;
  } cmd_info_t;

  // Per-state control vector; the *wb/memwr/branch bits mark where cond_ex gates a strobe.
  typedef struct packed {
    logic       adr_src;
    logic       ir_write;
    logic       pc_fetch;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       exec;
    logic       memwb;
    logic       memwr;
    logic       aluwb;
    logic       branch;
  } ctrl_t;

  function automatic cmd_info_t decode_cmd(input logic [3:0] cmd);
    cmd_info_t i;
    i = '{alu_control: ALU_ADD, valid: 1'b1, is_cmp: 1'b0, sets_cv: 1'b0};
    case (cmd)
      CMD_ADD: i.sets_cv = 1'b1;
      CMD_SUB: begin i.alu_control = ALU_SUB; i.sets_cv = 1'b1; end
      CMD_CMP: begin i.alu_control = ALU_SUB; i.sets_cv = 1'b1; i.is_cmp = 1'b1; end
      CMD_AND: i.alu_control = ALU_AND;
      CMD_ORR: i.alu_control = ALU_ORR;
      default: i.valid = 1'b0;
    endcase
    return i;
  endfunction

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.adr_src = ADR_PC; c.ir_write = 1'b1; c.pc_fetch = 1'b1;
        c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALU;
      end
      S_DECODE: begin c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALU; end
      S_MEMADR: c.alu_src_b = SRCB_IMM;
      S_MEMRD:  c.adr_src = ADR_ALUOUT;
      S_MEMWB:  begin c.result_src = RES_DATA; c.memwb = 1'b1; end
      S_MEMWR:  begin c.adr_src = ADR_ALUOUT; c.memwr = 1'b1; end
      S_EXECR:  c.exec = 1'b1;
      S_EXECI:  begin c.exec = 1'b1; c.alu_src_b = SRCB_IMM; end
      S_ALUWB:  begin c.result_src = RES_ALUOUT; c.aluwb = 1'b1; end
      S_BRANCH: begin c.alu_src_b = SRCB_IMM; c.result_src = RES_ALU; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [1:0] op, input logic [5:0] funct);
    state_t n;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: case (op)
                  2'b01:   n = S_MEMADR;
                  2'b00:   n = funct[5] ? S_EXECI : S_EXECR;
                  2'b10:   n = S_BRANCH;
                  default: n = S_FETCH;
                endcase
      S_MEMADR: n = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  n = S_MEMWB;
      S_EXECR, S_EXECI: n = S_ALUWB;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Instruction fields in, datapath controls out, between datapath (master) and sequencer (slave).
interface multi_cycle_control_if;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [3:0] state;

  modport master (
    output cond, op, funct, rd, alu_flags,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state
  );

  modport slave (
    input  cond, op, funct, rd, alu_flags,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src, reg_src, state
  );
endinterface

// File: rtl/multi_cycle_control_cond_unit.sv
// NZCV register and condition evaluator; cond_ex reflects the flags as currently held.
module cond_unit
  import arm_mc_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       exec,
  input  logic       s_bit,
  input  logic       is_cmp,
  input  logic       sets_cv,
  output logic       cond_ex
);

  logic [3:0] flags_q;
  logic       flag_we;

  assign cond_ex = cond_eval(cond, flags_q);
  assign flag_we = exec & cond_ex & (s_bit | is_cmp);

  // Logical ops leave C and V untouched, matching ARM's barrel-shifter-less subset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RESET_FLAGS;
    end else if (flag_we) begin
      flags_q[3:2] <= alu_flags[3:2];
      if (sets_cv) flags_q[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multicycle ARM sequencer: Moore FSM with registered per-state controls, strobes gated by cond_ex.
//   state  | meaning
//   FETCH  | IR <- mem[PC], PC <- PC+4        DECODE | read regs, PC+8 on result bus
//   MEMADR | ALUOut <- base + imm             MEMRD  | read mem[ALUOut]
//   MEMWB  | Rd <- Data                       MEMWR  | mem[ALUOut] <- Rd
//   EXECR  | ALU on reg B, flags may update   EXECI  | ALU on ExtImm, flags may update
//   ALUWB  | Rd <- ALUOut (not CMP)           BRANCH | PC <- PC+8 + imm
module multi_cycle_control
  import arm_mc_pkg::*;
#(
  parameter int         STATE_W     = 4,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_cycle_control_if.slave   bus
);

  state_t    state_q;
  ctrl_t     ctrl_q;
  cmd_info_t cmd_info;
  logic      cond_ex;
  logic      rd_is_pc;

  assign cmd_info = decode_cmd(bus.funct[4:1]);
  assign rd_is_pc = (bus.rd == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= next_state(state_q, bus.op, bus.funct);
      ctrl_q  <= state_ctrl(next_state(state_q, bus.op, bus.funct));
    end
  end

  cond_unit #(.RESET_FLAGS(RESET_FLAGS)) u_cond (
    .clk       (clk),
    .rst_n     (reset),
    .cond      (bus.cond),
    .alu_flags (bus.alu_flags),
    .exec      (ctrl_q.exec),
    .s_bit     (bus.funct[0]),
    .is_cmp    (cmd_info.is_cmp),
    .sets_cv   (cmd_info.sets_cv),
    .cond_ex   (cond_ex)
  );

  // Holding reset low kills every write strobe even though the controls sit at FETCH.
  assign bus.pc_write  = reset & (ctrl_q.pc_fetch |
                         (cond_ex & (ctrl_q.branch |
                          (rd_is_pc & (ctrl_q.memwb | (ctrl_q.aluwb & ~cmd_info.is_cmp))))));
  assign bus.reg_write = reset & cond_ex &
                         (ctrl_q.memwb | (ctrl_q.aluwb & ~cmd_info.is_cmp & cmd_info.valid));
  assign bus.mem_write = reset & cond_ex & ctrl_q.memwr;
  assign bus.ir_write  = reset & ctrl_q.ir_write;

  assign bus.adr_src     = ctrl_q.adr_src;
  assign bus.result_src  = ctrl_q.result_src;
  assign bus.alu_src_a   = ctrl_q.alu_src_a;
  assign bus.alu_src_b   = ctrl_q.alu_src_b;
  assign bus.alu_control = ctrl_q.exec ? cmd_info.alu_control : ALU_ADD;
  assign bus.imm_src     = bus.op;
  assign bus.reg_src     = {bus.op == 2'b01, bus.op == 2'b10};
  assign bus.state       = STATE_W'(state_q);

endmodule
